voice_engine: RTL and testbench

Parametrised sequential oscillator engine, successor to the fixed 3-voice generator. Time-multiplexes one arithmetic datapath across `NUM_VOICES` voices; each start request advances one voice's phase accumulator and noise LFSR and returns one registered sample. It adds test-bit control, request-time input capture, a registered output and a busy flag. It sits between the register-file sequencer, which issues one request per voice per sample tick, and the mixer/filter.

---
 rtl/voice_engine.sv | 179 +++++++++++++++++
 tb/tb_voice_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_engine.sv
// voice_engine: time-multiplexed oscillator engine. One shared datapath
// serves NUM_VOICES voices; each accepted request advances one voice's
// phase accumulator and noise LFSR and returns one registered sample.
// Optional build macro: VOICE_ENGINE_COMBINED_WAVE_EN (multi-bit wave
// selects AND the selected waveforms together; otherwise only one-hot
// selects produce output).
//
// state | meaning
// IDLE  | waiting for a start with an in-range voice index
// CALC  | next phase computed from captured request and stored voice state
// WRITE | waveform formed, voice state / wave_o / ready_o registered
module voice_engine #(
    parameter int NUM_VOICES = 3,
    parameter int ACC_W      = 19,
    parameter int FREQ_W     = 16,
    parameter int PW_W       = 12,
    parameter int OUT_W      = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [$clog2(NUM_VOICES)-1:0] voice_i,
    input  logic [FREQ_W-1:0]             freq_word_i,
    input  logic [PW_W-1:0]               pw_word_i,
    input  logic [3:0]                    wave_sel_i,
    input  logic                          sync_i,
    input  logic                          ring_mod_i,
    input  logic                          test_i,
    output logic                          busy_o,
    output logic                          ready_o,
    output logic signed [OUT_W-1:0]       wave_o
);

    localparam int VI_W = $clog2(NUM_VOICES);
    localparam logic [VI_W:0]   NV       = (VI_W+1)'(NUM_VOICES);
    localparam logic [VI_W-1:0] LAST     = VI_W'(NUM_VOICES - 1);
    localparam int              LFSR_BIT = ACC_W - 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state;
    logic              accept;
    logic [VI_W-1:0]   cap_voice;
    logic [VI_W-1:0]   src;
    logic [FREQ_W-1:0] cap_freq;
    logic [PW_W-1:0]   cap_pw;
    logic [3:0]        cap_sel;
    logic              cap_sync;
    logic              cap_ring;
    logic              cap_test;

    logic [ACC_W-1:0]      phase [NUM_VOICES];
    logic [22:0]           lfsr  [NUM_VOICES];
    logic [NUM_VOICES-1:0] rise;

    logic [ACC_W-1:0] cur_phase;
    logic [ACC_W-1:0] nph_c;
    logic [ACC_W-1:0] nph_q;
    logic [22:0]      cur_lfsr;
    logic [7:0]       taps;
    logic             fold;
    logic             lfsr_step;
    logic             rise_c;
    logic [OUT_W-1:0] t;
    logic [OUT_W-1:0] saw_w;
    logic [OUT_W-1:0] tri_w;
    logic [OUT_W-1:0] pulse_w;
    logic [OUT_W-1:0] noise_w;
    logic [OUT_W-1:0] sel_w;

    assign accept    = start_i && (state == S_IDLE) && ({1'b0, voice_i} < NV);
    assign src       = (cap_voice == '0) ? LAST : cap_voice - VI_W'(1);
    assign cur_phase = phase[cap_voice];
    assign busy_o    = (state != S_IDLE);

    // Next phase: wrapping add, cleared by hard sync (source just rose) or test.
    always_comb begin
        nph_c = cur_phase + ACC_W'(cap_freq);
        if (cap_sync && rise[src]) nph_c = '0;
        if (cap_test)              nph_c = '0;
    end

    // Per-waveform sample patterns and state-update conditions from the CALC result.
    always_comb begin
        cur_lfsr  = lfsr[cap_voice];
        taps      = {cur_lfsr[20], cur_lfsr[18], cur_lfsr[14], cur_lfsr[11],
                     cur_lfsr[9],  cur_lfsr[5],  cur_lfsr[2],  cur_lfsr[0]};
        saw_w     = nph_q[ACC_W-1 -: OUT_W];
        t         = nph_q[ACC_W-2 -: OUT_W];
        fold      = nph_q[ACC_W-1] ^ (cap_ring & phase[src][ACC_W-1]);
        tri_w     = (fold ? ~t : t) ^ {1'b1, {(OUT_W-1){1'b0}}};
        pulse_w   = (nph_q[ACC_W-1 -: PW_W] >= cap_pw) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                       : {1'b1, {(OUT_W-1){1'b0}}};
        noise_w   = OUT_W'({~taps[7], taps[6:0]}) << (OUT_W - 8);
        lfsr_step = !cur_phase[LFSR_BIT] && nph_q[LFSR_BIT];
        rise_c    = !cur_phase[ACC_W-1] && nph_q[ACC_W-1] && !cap_test;
    end

`ifdef VOICE_ENGINE_COMBINED_WAVE_EN
    // Combined mode: AND every selected waveform; an empty select is silent.
    always_comb begin
        sel_w = '1;
        if (cap_sel[0]) sel_w &= tri_w;
        if (cap_sel[1]) sel_w &= saw_w;
        if (cap_sel[2]) sel_w &= pulse_w;
        if (cap_sel[3]) sel_w &= noise_w;
        if (cap_sel == 4'b0000) sel_w = '0;
    end
`else
    // One-hot mode: any select that is not exactly one waveform is silent.
    always_comb begin
        sel_w = '0;
        case (cap_sel)
            4'b0001: sel_w = tri_w;
            4'b0010: sel_w = saw_w;
            4'b0100: sel_w = pulse_w;
            4'b1000: sel_w = noise_w;
            default: sel_w = '0;
        endcase
    end
`endif

    // Sequencer, request capture and per-voice state; reset aborts any request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            ready_o   <= 1'b0;
            wave_o    <= '0;
            cap_voice <= '0;
            cap_freq  <= '0;
            cap_pw    <= '0;
            cap_sel   <= '0;
            cap_sync  <= 1'b0;
            cap_ring  <= 1'b0;
            cap_test  <= 1'b0;
            nph_q     <= '0;
            rise      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                lfsr[i]  <= 23'h7FFFFF;
            end
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_voice <= voice_i;
                        cap_freq  <= freq_word_i;
                        cap_pw    <= pw_word_i;
                        cap_sel   <= wave_sel_i;
                        cap_sync  <= sync_i;
                        cap_ring  <= ring_mod_i;
                        cap_test  <= test_i;
                        state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    nph_q <= nph_c;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    phase[cap_voice] <= nph_q;
                    rise[cap_voice]  <= rise_c;
                    if (cap_test)
                        lfsr[cap_voice] <= 23'h7FFFFF;
                    else if (lfsr_step)
                        lfsr[cap_voice] <= {cur_lfsr[21:0], cur_lfsr[22] ^ cur_lfsr[17]};
                    wave_o  <= sel_w;
                    ready_o <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_engine.sv
// Self-checking bench for voice_engine (default parameters, 3 voices).
// Expected samples come from a behavioural voice model and are queued when a
// request is driven, then popped when ready_o appears.
module tb_voice_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  voice_i = '0;
    logic [15:0] freq_word_i = '0;
    logic [11:0] pw_word_i = '0;
    logic [3:0]  wave_sel_i = '0;
    logic        sync_i = 1'b0;
    logic        ring_mod_i = 1'b0;
    logic        test_i = 1'b0;
    logic        busy_o;
    logic        ready_o;
    logic signed [9:0] wave_o;

    int checks = 0;
    int failures = 0;

    logic [18:0] m_phase [3];
    logic [22:0] m_lfsr  [3];
    logic        m_rise  [3];
    logic [9:0]  exp_q [$];

    voice_engine dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .voice_i(voice_i),
        .freq_word_i(freq_word_i), .pw_word_i(pw_word_i), .wave_sel_i(wave_sel_i),
        .sync_i(sync_i), .ring_mod_i(ring_mod_i), .test_i(test_i),
        .busy_o(busy_o), .ready_o(ready_o), .wave_o(wave_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [9:0] model_wave(input logic [18:0] nph, input logic src_msb,
                                              input logic [22:0] l, input logic [11:0] pw,
                                              input logic [3:0] sel, input logic ring);
        logic [9:0] saw_v, tri_v, pul_v, noi_v, r;
        logic [18:0] sh;
        sh    = nph >> 9;
        saw_v = sh[9:0];
        sh    = nph >> 8;
        tri_v = sh[9:0];
        if (nph[18] != (ring && src_msb)) tri_v = 10'h3FF - tri_v;
        tri_v = tri_v + 10'h200;
        sh    = nph >> 7;
        pul_v = (sh[11:0] >= pw) ? 10'd511 : 10'h200;
        noi_v = {~l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0], 2'b00};
`ifdef VOICE_ENGINE_COMBINED_WAVE_EN
        r = 10'h3FF;
        if (sel[0]) r = r & tri_v;
        if (sel[1]) r = r & saw_v;
        if (sel[2]) r = r & pul_v;
        if (sel[3]) r = r & noi_v;
        if (sel == 4'd0) r = 10'd0;
`else
        if (sel == 4'd1)      r = tri_v;
        else if (sel == 4'd2) r = saw_v;
        else if (sel == 4'd4) r = pul_v;
        else if (sel == 4'd8) r = noi_v;
        else                  r = 10'd0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = '0;
            m_lfsr[i]  = 23'h7FFFFF;
            m_rise[i]  = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_req(input int v, input logic [15:0] f, input logic [11:0] pw,
                             input logic [3:0] sel, input logic sy, input logic rg,
                             input logic ts, output logic [9:0] e);
        int s;
        logic [18:0] old, nph;
        logic [22:0] l;
        s   = (v == 0) ? 2 : v - 1;
        old = m_phase[v];
        l   = m_lfsr[v];
        nph = old + {3'b000, f};
        if (sy && m_rise[s]) nph = '0;
        if (ts) nph = '0;
        e = model_wave(nph, m_phase[s][18], l, pw, sel, rg);
        m_rise[v] = !ts && !old[18] && nph[18];
        if (ts) m_lfsr[v] = 23'h7FFFFF;
        else if (!old[9] && nph[9]) m_lfsr[v] = {l[21:0], l[22] ^ l[17]};
        m_phase[v] = nph;
    endtask

    // Drive one request, push its expected sample, then wait for ready_o and compare.
    task automatic issue(input int v, input logic [15:0] f, input logic [11:0] pw,
                         input logic [3:0] sel, input logic sy, input logic rg,
                         input logic ts, output logic [9:0] got);
        logic [9:0] e;
        int seen;
        @(negedge clk_i);
        voice_i = 2'(v); freq_word_i = f; pw_word_i = pw; wave_sel_i = sel;
        sync_i = sy; ring_mod_i = rg; test_i = ts; start_i = 1'b1;
        model_req(v, f, pw, sel, sy, rg, ts, e);
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        freq_word_i = 16'($urandom); pw_word_i = 12'($urandom); wave_sel_i = 4'($urandom);
        sync_i = 1'($urandom); ring_mod_i = 1'($urandom); test_i = 1'($urandom);
        voice_i = 2'($urandom_range(0, 3));
        checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL accept: busy=%b ready=%b, required busy=1 ready=0", busy_o, ready_o);
        end
        seen = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk_i); #1;
            if (ready_o === 1'b1) begin seen = n; break; end
        end
        checks++;
        if (seen != 2 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_latency: ready after %0d edges busy=%b, required 2 edges busy=0", seen, busy_o);
        end
        e = exp_q.pop_front();
        got = wave_o;
        checks++;
        if (wave_o !== e) begin
            failures++;
            $display("FAIL wave v%0d sel=%h: got %h, required %h", v, sel, wave_o, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || wave_o !== 10'sd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b ready=%b wave=%h, required 0 0 000", busy_o, ready_o, wave_o);
        end
    endtask

    task automatic test_saw();
        logic [9:0] g;
        for (int k = 1; k <= 4; k++) begin
            issue(0, 16'h0200, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
            checks++;
            if (g !== 10'(k)) begin
                failures++;
                $display("FAIL saw_step%0d: got %0d, required %0d", k, $signed(g), k);
            end
        end
    endtask

    task automatic test_pulse();
        logic [9:0] g;
        for (int k = 1; k <= 128; k++) begin
            issue(1, 16'h1000, 12'h800, 4'b0100, 1'b0, 1'b0, 1'b0, g);
            if (k == 1 || k == 63 || k == 128) begin
                checks++;
                if (g !== 10'h200) begin
                    failures++;
                    $display("FAIL pulse_low_step%0d: got %0d, required -512", k, $signed(g));
                end
            end
            if (k == 64 || k == 127) begin
                checks++;
                if (g !== 10'h1FF) begin
                    failures++;
                    $display("FAIL pulse_high_step%0d: got %0d, required 511", k, $signed(g));
                end
            end
        end
    endtask

    task automatic test_test_bit();
        logic [9:0] g;
        for (int k = 0; k < 10; k++) issue(2, 16'h4000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        issue(2, 16'h4000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b1, g);
        issue(2, 16'h4000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd32) begin
            failures++;
            $display("FAIL test_bit_saw: got %0d, required 32", $signed(g));
        end
        issue(2, 16'h4000, 12'h0, 4'b1000, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'h1FC) begin
            failures++;
            $display("FAIL test_bit_noise: got %h, required 1fc", g);
        end
    endtask

    task automatic test_noise();
        logic [9:0] g;
        for (int k = 0; k < 24; k++) issue(0, 16'h0200, 12'h0, 4'b1000, 1'b0, 1'b0, 1'b0, g);
    endtask

    task automatic test_sync_ring();
        logic [9:0] g;
        do_reset();
        for (int k = 0; k < 4; k++) issue(0, 16'hFC00, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        issue(0, 16'h1000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        issue(1, 16'h1000, 12'h0, 4'b0010, 1'b1, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd0) begin
            failures++;
            $display("FAIL sync_reset: got %0d, required 0", $signed(g));
        end
        issue(1, 16'h1000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd8) begin
            failures++;
            $display("FAIL sync_off: got %0d, required 8", $signed(g));
        end
        issue(1, 16'h1000, 12'h0, 4'b0001, 1'b0, 1'b1, 1'b0, g);
        checks++;
        if (g !== 10'h1DF) begin
            failures++;
            $display("FAIL ring_tri: got %h, required 1df", g);
        end
        issue(1, 16'h1000, 12'h0, 4'b0001, 1'b0, 1'b0, 1'b0, g);
    endtask

    task automatic test_ignore();
        logic [9:0] e, g;
        int cnt, bad;
        @(negedge clk_i);
        voice_i = 2'd1; freq_word_i = 16'h0100; pw_word_i = '0; wave_sel_i = 4'b0010;
        sync_i = 1'b0; ring_mod_i = 1'b0; test_i = 1'b0; start_i = 1'b1;
        model_req(1, 16'h0100, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, e);
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        voice_i = 2'd2; freq_word_i = 16'hFFFF;
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            if (i == 2) start_i = 1'b0;
            if (ready_o === 1'b1) begin
                cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (wave_o !== e) begin
                        failures++;
                        $display("FAIL busy_start_wave: got %h, required %h", wave_o, e);
                    end
                end
            end
        end
        checks++;
        if (cnt != 1) begin
            failures++;
            $display("FAIL busy_start_ready_count: got %0d, required 1", cnt);
        end
        @(negedge clk_i);
        voice_i = 2'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy_o !== 1'b0 || ready_o !== 1'b0) bad++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bad_voice_ignored: %0d busy/ready cycles, required 0", bad);
        end
        issue(2, 16'h0400, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        issue(1, 16'h0100, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
    endtask

    task automatic test_reset_in_calc();
        logic [9:0] g;
        int bad;
        @(negedge clk_i);
        voice_i = 2'd0; freq_word_i = 16'h3000; wave_sel_i = 4'b0010; start_i = 1'b1;
        sync_i = 1'b0; ring_mod_i = 1'b0; test_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready_o !== 1'b0 || busy_o !== 1'b0) bad++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (bad != 0 || wave_o !== 10'sd0) begin
            failures++;
            $display("FAIL reset_in_calc: bad=%0d wave=%h, required 0 and 000", bad, wave_o);
        end
        issue(0, 16'h0200, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd1) begin
            failures++;
            $display("FAIL post_reset_saw: got %0d, required 1", $signed(g));
        end
    endtask

    task automatic test_combined();
        logic [9:0] g;
        do_reset();
        for (int k = 0; k < 3; k++) issue(0, 16'h8000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        issue(0, 16'h8000, 12'h0, 4'b0011, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd0) begin
            failures++;
            $display("FAIL combined_tri_saw: got %h, required 000", g);
        end
        for (int k = 0; k < 4; k++) issue(1, 16'h8000, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, g);
        checks++;
        if (g !== 10'd256) begin
            failures++;
            $display("FAIL single_saw_half: got %0d, required 256", $signed(g));
        end
    endtask

    task automatic test_back_to_back_random();
        logic [9:0] g;
        for (int k = 0; k < 40; k++)
            issue($urandom_range(0, 2), 16'($urandom), 12'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), g);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_saw();
        test_pulse();
        test_test_bit();
        test_noise();
        test_sync_ring();
        test_ignore();
        test_reset_in_calc();
        test_combined();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
